// File: rtl/bus_transfer_unit.sv
// rtl/bus_transfer_unit.sv - shared-bus register bank with a 3-step transfer sequencer
// Moves one word per request (external value or register) into a destination register over the bus.
module bus_transfer_unit #(
    parameter int WIDTH = 32,
    parameter int NREGS = 4,
    localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_ext,
    input  logic [SEL_W-1:0] req_src,
    input  logic [SEL_W-1:0] req_dst,
    input  logic [WIDTH-1:0] ext_data,
    output logic [WIDTH-1:0] bus_out,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_LATCH = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // One extra bit so the limit is representable when NREGS is a power of two.
    localparam logic [SEL_W:0] NREG_LIM = (SEL_W + 1)'(NREGS);

    state_t           state_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] bus_out_q;
    logic [SEL_W-1:0] dst_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic dst_bad;
    logic src_bad;

    assign dst_bad = ({1'b0, req_dst} >= NREG_LIM);
    assign src_bad = !req_ext && ({1'b0, req_src} >= NREG_LIM);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            bus_out_q <= '0;
            dst_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        dst_q  <= req_dst;
                        busy_q <= 1'b1;
                        if (dst_bad || src_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            // The source is sampled here, so the bus already carries it in DRIVE.
                            state_q   <= S_DRIVE;
                            bus_out_q <= req_ext ? ext_data : regs_q[req_src];
                        end
                    end
                end
                S_DRIVE: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    regs_q[dst_q] <= bus_out_q;
                    bus_out_q     <= '0;
                    done_q        <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_out_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_sel} < NREG_LIM) begin
            rd_data = regs_q[rd_sel];
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign bus_out   = bus_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_transfer_unit.sv
// tb/tb_bus_transfer_unit.sv - directed self-checking bench for bus_transfer_unit
module tb_bus_transfer_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_ext;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic [31:0] ext_data;

    logic        valid_a, ready_a, busy_a, done_a, err_a;
    logic [1:0]  rd_sel_a;
    logic [31:0] bus_a, rd_data_a;

    logic        valid_b, ready_b, busy_b, done_b, err_b;
    logic [3:0]  rd_sel_b;
    logic [7:0]  bus_b, rd_data_b;

    int checks = 0;
    int failures = 0;
    int done_cnt;

    always #5 clock = ~clock;

    bus_transfer_unit #(.WIDTH(32), .NREGS(3)) u_a (
        .clock(clock), .clear(clear),
        .req_valid(valid_a), .req_ready(ready_a), .req_ext(req_ext),
        .req_src(req_src[1:0]), .req_dst(req_dst[1:0]), .ext_data(ext_data),
        .bus_out(bus_a), .rd_sel(rd_sel_a), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    bus_transfer_unit #(.WIDTH(8), .NREGS(16)) u_b (
        .clock(clock), .clear(clear),
        .req_valid(valid_b), .req_ready(ready_b), .req_ext(req_ext),
        .req_src(req_src), .req_dst(req_dst), .ext_data(ext_data[7:0]),
        .bus_out(bus_b), .rd_sel(rd_sel_b), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req_a(input logic e, input logic [3:0] s, input logic [3:0] d, input logic [31:0] x);
        req_ext = e; req_src = s; req_dst = d; ext_data = x;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
    endtask

    task automatic req_b(input logic e, input logic [3:0] s, input logic [3:0] d, input logic [31:0] x);
        req_ext = e; req_src = s; req_dst = d; ext_data = x;
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
    endtask

    task automatic reg_a(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        rd_sel_a = sel;
        #1;
        check(tag, rd_data_a, exp);
    endtask

    initial begin
        clear = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        req_ext = 1'b0; req_src = '0; req_dst = '0; ext_data = '0;
        rd_sel_a = '0; rd_sel_b = '0;
        #12;
        check("rst_ready", {31'd0, ready_a}, 32'd1);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_bus", bus_a, 32'd0);
        for (int i = 0; i < 4; i++) reg_a("rst_rd", 2'(i), 32'd0);
        clear = 1'b1;
        tick();

        // Ext load 186 -> r1
        req_a(1'b1, 4'd0, 4'd1, 32'd186);
        check("ext_k1_bus", bus_a, 32'd186);
        check("ext_k1_busy", {31'd0, busy_a}, 32'd1);
        check("ext_k1_ready", {31'd0, ready_a}, 32'd0);
        check("ext_k1_done", {31'd0, done_a}, 32'd0);
        tick();
        check("ext_k2_bus", bus_a, 32'd186);
        reg_a("ext_k2_old", 2'd1, 32'd0);
        tick();
        check("ext_k3_done", {31'd0, done_a}, 32'd1);
        check("ext_k3_bus", bus_a, 32'd0);
        reg_a("ext_k3_r1", 2'd1, 32'd186);
        reg_a("ext_k3_r0", 2'd0, 32'd0);
        tick();
        check("ext_idle_done", {31'd0, done_a}, 32'd0);
        check("ext_idle_busy", {31'd0, busy_a}, 32'd0);
        check("ext_idle_ready", {31'd0, ready_a}, 32'd1);

        // Load 0 to r0, then move r1 -> r2
        req_a(1'b1, 4'd0, 4'd0, 32'd0);
        tick(); tick(); tick();
        req_a(1'b0, 4'd1, 4'd2, 32'hDEAD_BEEF);
        check("mov_k1_bus", bus_a, 32'd186);
        tick(); tick();
        check("mov_k3_done", {31'd0, done_a}, 32'd1);
        reg_a("mov_r2", 2'd2, 32'd186);
        reg_a("mov_r1", 2'd1, 32'd186);
        reg_a("mov_r0", 2'd0, 32'd0);
        tick();

        // Back-to-back: valid held, three accepts 4 cycles apart
        req_ext = 1'b1; req_src = 4'd0; req_dst = 4'd0; ext_data = 32'd5;
        valid_a = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("b2b_ready_%0d", i), {31'd0, ready_a}, {31'd0, (i % 4) == 3});
            check($sformatf("b2b_done_%0d", i), {31'd0, done_a}, {31'd0, (i % 4) == 2});
            if (done_a) done_cnt++;
        end
        valid_a = 1'b0;
        tick();
        check("b2b_done_cnt", done_cnt, 32'd3);
        check("b2b_idle", {31'd0, ready_a}, 32'd1);
        reg_a("b2b_r0", 2'd0, 32'd5);

        // Bad destination index
        req_a(1'b1, 4'd0, 4'd3, 32'd99);
        check("err_dst_pulse", {31'd0, err_a}, 32'd1);
        check("err_dst_busy", {31'd0, busy_a}, 32'd1);
        check("err_dst_bus", bus_a, 32'd0);
        check("err_dst_done", {31'd0, done_a}, 32'd0);
        tick();
        check("err_dst_clr", {31'd0, err_a}, 32'd0);
        check("err_dst_ready", {31'd0, ready_a}, 32'd1);
        // Bad source index
        req_a(1'b0, 4'd3, 4'd0, 32'd99);
        check("err_src_pulse", {31'd0, err_a}, 32'd1);
        tick();
        reg_a("err_r0", 2'd0, 32'd5);
        reg_a("err_r1", 2'd1, 32'd186);
        reg_a("err_r2", 2'd2, 32'd186);

        // src == dst
        req_a(1'b0, 4'd2, 4'd2, 32'd0);
        tick(); tick();
        check("same_done", {31'd0, done_a}, 32'd1);
        reg_a("same_r2", 2'd2, 32'd186);
        tick();

        // Reset in the LATCH cycle aborts the transfer
        req_a(1'b1, 4'd0, 4'd1, 32'd77);
        tick();
        clear = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_a}, 32'd0);
        check("arst_ready", {31'd0, ready_a}, 32'd1);
        check("arst_bus", bus_a, 32'd0);
        for (int i = 0; i < 4; i++) reg_a("arst_rd", 2'(i), 32'd0);
        #2;
        clear = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_a) done_cnt++;
        end
        check("arst_no_done", done_cnt, 32'd0);
        reg_a("arst_r1", 2'd1, 32'd0);

        // Wide index instance: 8-bit, 16 registers
        req_b(1'b1, 4'd0, 4'd15, 32'h0000_00FF);
        tick(); tick();
        check("w_done1", {31'd0, done_b}, 32'd1);
        tick();
        req_b(1'b0, 4'd15, 4'd0, 32'h0000_0011);
        check("w_mov_bus", {24'd0, bus_b}, 32'hFF);
        tick(); tick();
        check("w_done2", {31'd0, done_b}, 32'd1);
        rd_sel_b = 4'd0; #1;
        check("w_r0", {24'd0, rd_data_b}, 32'hFF);
        rd_sel_b = 4'd15; #1;
        check("w_r15", {24'd0, rd_data_b}, 32'hFF);
        rd_sel_b = 4'd7; #1;
        check("w_r7", {24'd0, rd_data_b}, 32'd0);
        tick();
        check("w_idle_bus", {24'd0, bus_b}, 32'd0);
        check("w_idle_err", {31'd0, err_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
